alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked successor to the single-cycle datapath ALU. Takes one operation per accepted input beat, registers the result plus a full flag set (zero, negative, carry, overflow, illegal) on a valid/ready output port. Adds variable-amount and arithmetic shifts, signed and unsigned compares, and an optional iterative multiply. Sits between the decode/issue stage and writeback; backpressure from writeback stalls issue.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Must be a power of two and at least 4.
- `MUL_EN`, 1: 1 implements opcode MUL; 0 makes MUL illegal and removes the multiplier.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation beat present.
- `in_ready`  out  1  block can accept a beat this cycle.
- `op`  in  4  opcode, per `alu_pkg`.
- `operand_a`  in  WIDTH  first operand.
- `operand_b`  in  WIDTH  second operand; low `$clog2(WIDTH)` bits are the shift amount.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  operation result.
- `flags`  out  5  {illegal, overflow, carry, negative, zero}.

## Operation
Opcodes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT (of a).
- 6 SLL, 7 SRL, 8 SRA: a shifted by b[SH-1:0], where SH = `$clog2(WIDTH)`.
- 9 SLT (signed a<b, result 1/0), 10 SLTU (unsigned).
- 11 MUL: low WIDTH bits of a*b, unsigned.
- 12–15: illegal.

Flags are computed from the result of the same operation, never from the previous one:
- zero: result == 0.
- negative: result[WIDTH-1].
- carry: carry-out for ADD; borrow (a <u b) for SUB; 0 for all other ops.
- overflow: signed overflow for ADD/SUB only; 0 otherwise.
- illegal: set for opcodes 12–15, and for MUL when `MUL_EN`=0. Result is 0 in these cases, so zero = 1.

Width rules:
- All arithmetic is modulo 2^WIDTH.
- SRA replicates a[WIDTH-1].
- Shift amount 0 passes a unchanged.

FSM states:
- IDLE: accepts beats. A non-MUL op loads the output register directly. MUL goes to MUL.
- MUL: shift-add one bit of b per cycle for WIDTH cycles, then loads the output register and returns to IDLE. Runs only when `MUL_EN`=1.
- The output register holds `result`/`flags` stable while out_valid=1 and out_ready=0.

Handshake:
- A transfer happens on an edge where valid and ready are both 1.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Inputs are sampled only on an accepted edge.
- Once out_valid rises, it stays high until out_ready is seen.

## Timing
- Reset values: in_ready=0 during rst, then 1. out_valid=0, result=0, flags=0, state=IDLE.
- Non-MUL latency: accepted on edge N, out_valid=1 after edge N.
- Throughput for non-MUL ops is one per cycle while out_ready=1. Accept and drain in the same cycle is legal, and the new result replaces the old one on that edge.
- MUL latency: out_valid rises WIDTH+1 edges after acceptance. in_ready=0 from acceptance until the MUL result has been taken.
- Backpressure: out_ready=0 with out_valid=1 forces in_ready=0 and leaves the output unchanged.
- Reset asserted mid-MUL or with a pending output: the operation and the output are discarded and everything returns to reset values asynchronously. No partial result appears after reset is released.
- An illegal op takes the 1-cycle path.

## Structure
- `alu_pkg` holds:
  - the opcode enum `alu_op_e` (values above);
  - the flags struct `alu_flags_t` (field order as in the `flags` port);
  - the FSM state enum.
- Sub-module `alu_mul_seq` is the iterative shift-add multiplier with start/done. It is generated only when `MUL_EN`=1.
- The top holds the combinational op decode, the flag logic, the FSM and the output register.

## Test plan
- Reset, then ADD 0xFFFFFFFF+1 with out_ready=1 → result 0, zero=1, carry=1, overflow=0, out_valid one cycle after acceptance.
- SUB 0x80000000−1 → result 0x7FFFFFFF, overflow=1, carry(borrow)=0, negative=0. SLT 0xFFFFFFFF,1 → 1. SLTU with the same operands → 0.
- SRA 0x80000000 by b=0x21 (amount 1) → 0xC0000000. SLL by 0 → a unchanged. Opcode 13 → result 0, illegal=1, zero=1.
- MUL 0x00010003 × 0x00020005 → 0x000B000F, valid after WIDTH+1=33 edges. in_ready=0 throughout. Assert rst at cycle 10 of a second MUL → out_valid never rises for it.
- Back-to-back ADD stream with out_ready toggling pseudo-randomly → every result delivered once, in order, and held stable while stalled. Throughput is 1 per cycle when out_ready=1.
- `WIDTH`=8, `MUL_EN`=0: ADD 0x7F+1 → 0x80, overflow=1, negative=1. MUL op → illegal=1, 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag and FSM state types shared by the pipelined ALU
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MUL  = 4'd11
  } alu_op_e;
  typedef struct packed {
    logic illegal;
    logic overflow;
    logic carry;
    logic negative;
    logic zero;
  } alu_flags_t;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one bit of b per cycle, low WIDTH bits of a*b
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic [CW-1:0] cnt;
  logic busy;
  assign done = busy && (cnt == '0);
  assign product = acc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      mcand <= a;
      mplier <= b;
      acc <= '0;
      cnt <= CW'(WIDTH);
      busy <= 1'b1;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      acc <= acc + (mplier[0] ? mcand : '0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result/flags and optional iterative multiply
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);
  localparam int SH = $clog2(WIDTH);
  alu_state_e state, state_d;
  alu_flags_t alu_flags, mul_flags, flags_q;
  logic [WIDTH-1:0] alu_res, mul_prod;
  logic [WIDTH:0] sum, diff;
  logic [SH-1:0] sh;
  logic accept, is_mul, mul_done, load_alu, load_mul, c, v, ill;
  assign sum = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff = {1'b0, operand_a} - {1'b0, operand_b};
  assign sh = operand_b[SH-1:0];
  assign is_mul = MUL_EN && (op == OP_MUL);
  assign in_ready = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign load_alu = accept && !is_mul;
  assign load_mul = (state == ST_MUL) && mul_done;
  always_comb begin
    alu_res = '0;
    c = 1'b0;
    v = 1'b0;
    ill = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        c = diff[WIDTH];
        v = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (diff[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_AND:  alu_res = operand_a & operand_b;
      OP_OR:   alu_res = operand_a | operand_b;
      OP_XOR:  alu_res = operand_a ^ operand_b;
      OP_NOT:  alu_res = ~operand_a;
      OP_SLL:  alu_res = operand_a << sh;
      OP_SRL:  alu_res = operand_a >> sh;
      OP_SRA:  alu_res = $unsigned($signed(operand_a) >>> sh);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
      OP_MUL:  ill = !MUL_EN;
      default: ill = 1'b1;
    endcase
  end
  assign alu_flags = '{illegal: ill, overflow: v, carry: c, negative: alu_res[WIDTH-1], zero: alu_res == '0};
  assign mul_flags = '{illegal: 1'b0, overflow: 1'b0, carry: 1'b0, negative: mul_prod[WIDTH-1], zero: mul_prod == '0};
  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_mul),
        .a      (operand_a),
        .b      (operand_b),
        .done   (mul_done),
        .product(mul_prod)
      );
    end else begin : g_no_mul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate
  always_comb state_d = (state == ST_IDLE) ? ((accept && is_mul) ? ST_MUL : ST_IDLE) : (mul_done ? ST_IDLE : ST_MUL);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      out_valid <= 1'b0;
      result <= '0;
      flags_q <= '0;
    end else begin
      state <= state_d;
      out_valid <= (load_alu || load_mul) ? 1'b1 : (out_ready ? 1'b0 : out_valid);
      if (load_alu) begin
        result <= alu_res;
        flags_q <= alu_flags;
      end else if (load_mul) begin
        result <= mul_prod;
        flags_q <= mul_flags;
      end
    end
  end
  assign flags = flags_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for 32-bit (with MUL) and 8-bit (no MUL) alu_pipe
module tb_alu_pipe;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [3:0] op = '0;
  logic [31:0] operand_a = '0, operand_b = '0, result;
  logic [4:0] flags;
  logic in_valid8 = 1'b0, out_ready8 = 1'b1, in_ready8, out_valid8;
  logic [3:0] op8 = '0;
  logic [7:0] operand_a8 = '0, operand_b8 = '0, result8;
  logic [4:0] flags8;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );
  alu_pipe #(.WIDTH(8), .MUL_EN(1'b0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .operand_a(operand_a8), .operand_b(operand_b8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .flags(flags8)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic op32(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_r, input logic [4:0] exp_f);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    #1 check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".result"}, 64'(result), 64'(exp_r));
    check({tag, ".flags"}, 64'(flags), 64'(exp_f));
  endtask
  logic [31:0] exp_q[20];
  initial begin
    int cnt, issued, taken, budget;
    bit ir_low, seen;
    logic acc, drn, stall;
    logic [31:0] held;
    #2;
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.flags", 64'(flags), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst.in_ready", 64'(in_ready), 64'd1);
    op32("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b00101);
    op32("sub_ovf", 4'd1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 5'b01000);
    op32("sub_borrow", 4'd1, 32'h1, 32'h2, 32'hFFFF_FFFF, 5'b00110);
    op32("slt", 4'd9, 32'hFFFF_FFFF, 32'h1, 32'h1, 5'b00000);
    op32("sltu", 4'd10, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'b00001);
    op32("sra", 4'd8, 32'h8000_0000, 32'h21, 32'hC000_0000, 5'b00010);
    op32("sll0", 4'd6, 32'h1234_5678, 32'h0, 32'h1234_5678, 5'b00000);
    op32("srl4", 4'd7, 32'h8000_0000, 32'h4, 32'h0800_0000, 5'b00000);
    op32("xor", 4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'b00000);
    op32("not", 4'd5, 32'h0, 32'h0, 32'hFFFF_FFFF, 5'b00010);
    op32("illegal13", 4'd13, 32'h1234_5678, 32'h9, 32'h0, 5'b10001);
    @(negedge clk);
    in_valid = 1'b1;
    op = 4'd11;
    operand_a = 32'h0001_0003;
    operand_b = 32'h0002_0005;
    #1 check("mul.in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    cnt = 0;
    ir_low = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 50 && !seen; i++) begin
      if (in_ready) ir_low = 1'b0;
      @(posedge clk);
      #1 if (out_valid) begin
        seen = 1'b1;
        cnt = i;
      end
    end
    check("mul.latency", 64'(cnt), 64'd33);
    check("mul.in_ready_low", 64'(ir_low), 64'd1);
    check("mul.result", 64'(result), 64'h000B_000F);
    check("mul.flags", 64'(flags), 64'd0);
    @(posedge clk);
    #1 check("mul.drained", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b1;
    op = 4'd11;
    operand_a = 32'h7;
    operand_b = 32'h9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("mulrst.out_valid", 64'(out_valid), 64'd0);
    check("mulrst.in_ready", 64'(in_ready), 64'd0);
    check("mulrst.result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check("mulrst.no_valid", 64'(seen), 64'd0);
    for (int k = 0; k < 20; k++) exp_q[k] = (32'(k) * 32'h0101_0101) + (32'h10 + 32'(k));
    issued = 0;
    taken = 0;
    budget = 0;
    while (taken < 20 && budget < 300) begin
      @(negedge clk);
      budget++;
      out_ready = 1'($urandom_range(0, 1));
      in_valid = (issued < 20);
      op = 4'd0;
      operand_a = 32'(issued) * 32'h0101_0101;
      operand_b = 32'h10 + 32'(issued);
      #1;
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      stall = out_valid && !out_ready;
      held = result;
      if (out_ready && issued < 20) check("stream.in_ready", 64'(in_ready), 64'd1);
      if (drn) begin
        check($sformatf("stream.res%0d", taken), 64'(result), 64'(exp_q[taken]));
        taken++;
      end
      @(posedge clk);
      #1;
      if (acc) issued++;
      if (stall) begin
        check("stream.hold_valid", 64'(out_valid), 64'd1);
        check("stream.hold_result", 64'(result), 64'(held));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream.count", 64'(taken), 64'd20);
    @(negedge clk);
    in_valid8 = 1'b1;
    op8 = 4'd0;
    operand_a8 = 8'h7F;
    operand_b8 = 8'h01;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    check("w8_add.out_valid", 64'(out_valid8), 64'd1);
    check("w8_add.result", 64'(result8), 64'h80);
    check("w8_add.flags", 64'(flags8), 64'b01010);
    @(negedge clk);
    in_valid8 = 1'b1;
    op8 = 4'd11;
    operand_a8 = 8'h03;
    operand_b8 = 8'h05;
    #1 check("w8_mul.in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    check("w8_mul.out_valid", 64'(out_valid8), 64'd1);
    check("w8_mul.result", 64'(result8), 64'h0);
    check("w8_mul.flags", 64'(flags8), 64'b10001);
    @(posedge clk);
    #1 check("w8_mul.in_ready_after", 64'(in_ready8), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
